// File: rtl/cpu_dump_pkg.sv
// Shared types and constants for the CPU state dumper: FSM states, record tag
// kinds and the fixed layout of the header records.
package cpu_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    REG  = 2'd2,
    MEM  = 2'd3
  } dump_state_e;

  localparam logic [1:0] TAG_HDR = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

  localparam logic [5:0] HDR_CYCLE = 6'd0;
  localparam logic [5:0] HDR_STALL = 6'd1;
  localparam logic [5:0] HDR_FLUSH = 6'd2;
  localparam logic [5:0] HDR_PC    = 6'd3;

  localparam int IDX_W = 6;

  function automatic logic [7:0] make_tag(input logic [1:0] kind, input logic [5:0] idx);
    return {kind, idx};
  endfunction

endpackage

// File: rtl/cpu_state_dumper_if.sv
// Record stream between the dumper (master) and its consumer (slave).
interface cpu_state_dumper_if;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [7:0]  out_tag_o;
  logic        out_last_o;

  modport master (output out_valid_o, out_data_o, out_tag_o, out_last_o,
                  input  out_ready_i);
  modport slave  (input  out_valid_o, out_data_o, out_tag_o, out_last_o,
                  output out_ready_i);
endinterface

// File: rtl/perf_counters.sv
// Saturating cycle/stall/flush counters; all three advance only while the CPU runs.
module perf_counters #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          flush,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cycle_r;
  logic [CW-1:0] stall_r;
  logic [CW-1:0] flush_r;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Counter registers; stall and flush may both step in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_r <= {CW{1'b0}};
      stall_r <= {CW{1'b0}};
      flush_r <= {CW{1'b0}};
    end else if (start) begin
      cycle_r <= sat_inc(cycle_r);
      if (stall) begin
        stall_r <= sat_inc(stall_r);
      end
      if (flush) begin
        flush_r <= sat_inc(flush_r);
      end
    end
  end

  assign cycle_cnt = cycle_r;
  assign stall_cnt = stall_r;
  assign flush_cnt = flush_r;

endmodule

// File: rtl/cpu_state_dumper.sv
// Snapshot dumper: counts CPU cycles/stalls/flushes and, on request, streams a
// header, the register file and data-memory words as tagged records.
module cpu_state_dumper
  import cpu_dump_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int NWORD = 8,
  parameter int CW    = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  cpu_state_dumper_if.master out_if,
  output logic        busy_o
);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NREG - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(NWORD - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  logic [CW-1:0]    cycle_cnt_s, stall_cnt_s, flush_cnt_s;
  dump_state_e      state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [CW-1:0]    cyc_sh_r, stl_sh_r, fls_sh_r;
  logic [CW-1:0]    cyc_sh_nxt_s, stl_sh_nxt_s, fls_sh_nxt_s;
  logic [31:0]      pc_sh_r, pc_sh_nxt_s;
  logic             valid_r, valid_nxt_s, last_r, last_nxt_s, busy_r, busy_nxt_s;
  logic [31:0]      data_r, data_nxt_s;
  logic [7:0]       tag_r, tag_nxt_s;
  logic [4:0]       reg_addr_r, reg_addr_nxt_s;
  logic [31:0]      mem_addr_r, mem_addr_nxt_s;
  logic             load_s;

  perf_counters #(.CW(CW)) u_perf (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .start     (start_i),
    .stall     (stall_i),
    .flush     (flush_i),
    .cycle_cnt (cycle_cnt_s),
    .stall_cnt (stall_cnt_s),
    .flush_cnt (flush_cnt_s)
  );

  assign load_s = !valid_r || out_if.out_ready_i;

  // FSM sequencing, next record selection and read-address steering
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    valid_nxt_s  = valid_r;
    data_nxt_s   = data_r;
    tag_nxt_s    = tag_r;
    last_nxt_s   = last_r;
    cyc_sh_nxt_s = cyc_sh_r;
    stl_sh_nxt_s = stl_sh_r;
    fls_sh_nxt_s = fls_sh_r;
    pc_sh_nxt_s  = pc_sh_r;
    case (state_r)
      IDLE: begin
        // A new dump may only start once the previous last record has left
        if (!valid_r && dump_req_i) begin
          cyc_sh_nxt_s = cycle_cnt_s;
          stl_sh_nxt_s = stall_cnt_s;
          fls_sh_nxt_s = flush_cnt_s;
          pc_sh_nxt_s  = pc_i;
          valid_nxt_s  = 1'b1;
          data_nxt_s   = 32'(cycle_cnt_s);
          tag_nxt_s    = make_tag(TAG_HDR, HDR_CYCLE);
          last_nxt_s   = 1'b0;
          state_nxt_s  = HDR;
          idx_nxt_s    = IDX_ONE;
        end else if (out_if.out_ready_i) begin
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
        end else begin
          valid_nxt_s = valid_r;
        end
      end
      HDR: begin
        if (load_s) begin
          valid_nxt_s = 1'b1;
          tag_nxt_s   = make_tag(TAG_HDR, idx_r);
          case (idx_r)
            HDR_STALL: data_nxt_s = 32'(stl_sh_r);
            HDR_FLUSH: data_nxt_s = 32'(fls_sh_r);
            HDR_PC:    data_nxt_s = pc_sh_r;
            default:   data_nxt_s = 32'(cyc_sh_r);
          endcase
          if (idx_r == HDR_PC) begin
            state_nxt_s = REG;
            idx_nxt_s   = IDX_ZERO;
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      REG: begin
        if (load_s) begin
          valid_nxt_s = 1'b1;
          data_nxt_s  = reg_data_i;
          tag_nxt_s   = make_tag(TAG_REG, idx_r);
          if (idx_r == REG_LAST) begin
            state_nxt_s = MEM;
            idx_nxt_s   = IDX_ZERO;
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      MEM: begin
        if (load_s) begin
          valid_nxt_s = 1'b1;
          data_nxt_s  = mem_data_i;
          tag_nxt_s   = make_tag(TAG_MEM, idx_r);
          if (idx_r == MEM_LAST) begin
            last_nxt_s  = 1'b1;
            state_nxt_s = IDLE;
            idx_nxt_s   = IDX_ZERO;
          end else begin
            last_nxt_s = 1'b0;
            idx_nxt_s  = idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = IDX_ZERO;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
      end
    endcase

    // Addresses follow the index only inside their own section, so the read
    // data is valid for idx_r on the cycle the record is loaded
    if (state_nxt_s == REG) begin
      reg_addr_nxt_s = idx_nxt_s[4:0];
    end else begin
      reg_addr_nxt_s = reg_addr_r;
    end
    if (state_nxt_s == MEM) begin
      mem_addr_nxt_s = {{(32-IDX_W-2){1'b0}}, idx_nxt_s, 2'b00};
    end else begin
      mem_addr_nxt_s = mem_addr_r;
    end
    busy_nxt_s = (state_nxt_s != IDLE) || valid_nxt_s;
  end

  // State, shadow and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      idx_r      <= IDX_ZERO;
      cyc_sh_r   <= {CW{1'b0}};
      stl_sh_r   <= {CW{1'b0}};
      fls_sh_r   <= {CW{1'b0}};
      pc_sh_r    <= 32'd0;
      valid_r    <= 1'b0;
      data_r     <= 32'd0;
      tag_r      <= 8'd0;
      last_r     <= 1'b0;
      busy_r     <= 1'b0;
      reg_addr_r <= 5'd0;
      mem_addr_r <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      cyc_sh_r   <= cyc_sh_nxt_s;
      stl_sh_r   <= stl_sh_nxt_s;
      fls_sh_r   <= fls_sh_nxt_s;
      pc_sh_r    <= pc_sh_nxt_s;
      valid_r    <= valid_nxt_s;
      data_r     <= data_nxt_s;
      tag_r      <= tag_nxt_s;
      last_r     <= last_nxt_s;
      busy_r     <= busy_nxt_s;
      reg_addr_r <= reg_addr_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
    end
  end

  assign out_if.out_valid_o = valid_r;
  assign out_if.out_data_o  = data_r;
  assign out_if.out_tag_o   = tag_r;
  assign out_if.out_last_o  = last_r;
  assign busy_o             = busy_r;
  assign reg_addr_o         = reg_addr_r;
  assign mem_addr_o         = mem_addr_r;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed bench for cpu_state_dumper: a full-size instance plus a CW=4 instance
// sharing all stimulus, with register file and data memory modelled here.
module tb_cpu_state_dumper;
  import cpu_dump_pkg::*;

  localparam int NREG = 32;
  localparam int NWORD = 8;
  localparam int NREC = 4 + NREG + NWORD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stall = 1'b0, flush = 1'b0, dump_req = 1'b0, ready = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [4:0]  reg_addr, s_reg_addr;
  logic [31:0] mem_addr, s_mem_addr, reg_data, s_reg_data, mem_data, s_mem_data;
  logic        busy, s_busy;
  logic [31:0] regs [NREG];
  logic [7:0]  mem [64];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  logic [7:0]  q_tag[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic [31:0] sq_data[$];

  cpu_state_dumper_if oif ();
  cpu_state_dumper_if sif ();

  assign oif.out_ready_i = ready;
  assign sif.out_ready_i = ready;
  assign reg_data   = regs[reg_addr];
  assign s_reg_data = regs[s_reg_addr];
  assign mem_data   = {mem[mem_addr[5:0] + 6'd3], mem[mem_addr[5:0] + 6'd2],
                       mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]};
  assign s_mem_data = {mem[s_mem_addr[5:0] + 6'd3], mem[s_mem_addr[5:0] + 6'd2],
                       mem[s_mem_addr[5:0] + 6'd1], mem[s_mem_addr[5:0]]};

  cpu_state_dumper #(.NREG(NREG), .NWORD(NWORD), .CW(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .dump_req_i(dump_req), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data), .out_if(oif), .busy_o(busy));

  cpu_state_dumper #(.NREG(NREG), .NWORD(NWORD), .CW(4)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .dump_req_i(dump_req), .reg_addr_o(s_reg_addr), .reg_data_i(s_reg_data),
    .mem_addr_o(s_mem_addr), .mem_data_i(s_mem_data), .out_if(sif), .busy_o(s_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_tag(input int k);
    if (k < 4) return {TAG_HDR, 6'(k)};
    else if (k < 4 + NREG) return {TAG_REG, 6'(k - 4)};
    else return {TAG_MEM, 6'(k - 4 - NREG)};
  endfunction

  function automatic logic [31:0] exp_data(input int k, input logic [31:0] h0, h1, h2, h3);
    int a;
    if (k == 0) return h0;
    else if (k == 1) return h1;
    else if (k == 2) return h2;
    else if (k == 3) return h3;
    else if (k < 4 + NREG) return regs[k - 4];
    else begin
      a = 4 * (k - 4 - NREG);
      return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    end
  endfunction

  // Optionally pulses dump_req, then accepts records with ready high until the last one
  task automatic drain(input bit pulse, output bit tmo);
    q_data.delete(); q_tag.delete(); q_last.delete(); q_cyc.delete(); sq_data.delete();
    tmo = 1'b1;
    ready = 1'b1;
    if (pulse) begin
      dump_req = 1'b1;
      step();
      dump_req = 1'b0;
    end
    for (int i = 0; i < 300; i++) begin
      if (oif.out_valid_o && ready) begin
        q_data.push_back(oif.out_data_o);
        q_tag.push_back(oif.out_tag_o);
        q_last.push_back(oif.out_last_o);
        q_cyc.push_back(cyc);
        if (sif.out_valid_o) sq_data.push_back(sif.out_data_o);
        if (oif.out_last_o) begin
          tmo = 1'b0;
          step();
          break;
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_chk += 7;
    if (oif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", oif.out_valid_o); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (oif.out_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", oif.out_data_o); end
    if (oif.out_tag_o !== 8'd0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", oif.out_tag_o); end
    if (oif.out_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", oif.out_last_o); end
    if (reg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_reg_addr: got %h expected 0", reg_addr); end
    if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_counts();
    bit tmo;
    int req_c;
    pc = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; stall = (i < 3); flush = (i >= 3 && i < 5);
      step();
    end
    start = 1'b0; stall = 1'b0; flush = 1'b0;
    req_c = cyc;
    drain(1'b1, tmo);
    n_chk += 2;
    if (tmo) begin n_fail++; $display("FAIL counts_timeout: no last record within bound"); end
    if (q_cyc[0] !== req_c + 1) begin n_fail++; $display("FAIL counts_latency: first valid at cycle %0d expected %0d", q_cyc[0], req_c + 1); end
    for (int k = 0; k < 4; k++) begin
      n_chk += 2;
      if (q_data[k] !== exp_data(k, 32'd10, 32'd3, 32'd2, 32'h40)) begin
        n_fail++; $display("FAIL counts_hdr%0d: got %h expected %h", k, q_data[k], exp_data(k, 32'd10, 32'd3, 32'd2, 32'h40));
      end
      if (q_tag[k] !== 8'(k)) begin n_fail++; $display("FAIL counts_tag%0d: got %h expected %h", k, q_tag[k], 8'(k)); end
    end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    drain(1'b1, tmo);
    n_chk += 3;
    if (tmo) begin n_fail++; $display("FAIL b2b_timeout: no last record within bound"); end
    if (q_data.size() != NREC) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", q_data.size(), NREC); end
    if (q_cyc[NREC-1] - q_cyc[0] !== NREC - 1) begin n_fail++; $display("FAIL b2b_span: got %0d expected %0d", q_cyc[NREC-1] - q_cyc[0], NREC - 1); end
    for (int k = 0; k < NREC; k++) begin
      n_chk += 3;
      if (q_data[k] !== exp_data(k, 32'd10, 32'd3, 32'd2, 32'h40)) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", k, q_data[k], exp_data(k, 32'd10, 32'd3, 32'd2, 32'h40)); end
      if (q_tag[k] !== exp_tag(k)) begin n_fail++; $display("FAIL b2b_tag%0d: got %h expected %h", k, q_tag[k], exp_tag(k)); end
      if (q_last[k] !== (k == NREC - 1)) begin n_fail++; $display("FAIL b2b_last%0d: got %b expected %b", k, q_last[k], (k == NREC - 1)); end
    end
  endtask

  task automatic test_ready_stall();
    bit held_prev = 1'b0, hold_done = 1'b0, done = 1'b0;
    logic [31:0] pd, saved;
    logic [7:0]  pt;
    logic        pl;
    int hold = 0;
    q_data.delete(); q_tag.delete(); q_last.delete();
    ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (held_prev) begin
        n_chk++;
        if (oif.out_valid_o !== 1'b1 || oif.out_data_o !== pd || oif.out_tag_o !== pt || oif.out_last_o !== pl) begin
          n_fail++; $display("FAIL stall_hold: got %b/%h/%h/%b expected 1/%h/%h/%b",
            oif.out_valid_o, oif.out_data_o, oif.out_tag_o, oif.out_last_o, pd, pt, pl);
        end
      end
      if (hold > 0) begin
        ready = 1'b0;
        hold--;
        if (hold == 0) regs[6] = saved;
      end else if (!hold_done && oif.out_valid_o && oif.out_tag_o == {TAG_REG, 6'd6}) begin
        hold_done = 1'b1; hold = 4; ready = 1'b0;
        saved = regs[6]; regs[6] = 32'hBAD0_0006;
      end else begin
        ready = (i % 2 == 0);
      end
      held_prev = oif.out_valid_o && !ready;
      pd = oif.out_data_o; pt = oif.out_tag_o; pl = oif.out_last_o;
      if (oif.out_valid_o && ready) begin
        q_data.push_back(oif.out_data_o); q_tag.push_back(oif.out_tag_o); q_last.push_back(oif.out_last_o);
        if (oif.out_last_o) done = 1'b1;
      end
      step();
    end
    ready = 1'b1;
    n_chk += 3;
    if (!done) begin n_fail++; $display("FAIL stall_timeout: no last record within bound"); end
    if (!hold_done) begin n_fail++; $display("FAIL stall_window: REG idx6 never observed"); end
    if (q_data.size() != NREC) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", q_data.size(), NREC); end
    for (int k = 0; k < NREC; k++) begin
      n_chk += 2;
      if (q_data[k] !== exp_data(k, 32'd10, 32'd3, 32'd2, 32'h40)) begin n_fail++; $display("FAIL stall_data%0d: got %h expected %h", k, q_data[k], exp_data(k, 32'd10, 32'd3, 32'd2, 32'h40)); end
      if (q_tag[k] !== exp_tag(k)) begin n_fail++; $display("FAIL stall_tag%0d: got %h expected %h", k, q_tag[k], exp_tag(k)); end
    end
  endtask

  task automatic test_req_held();
    int nlast = 0, idle_obs = 0;
    q_data.delete(); q_tag.delete();
    ready = 1'b1;
    dump_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 20) dump_req = 1'b0;
      if (i == 21) dump_req = 1'b1;
      if (nlast == 1 && !oif.out_valid_o) begin
        idle_obs++;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL held_idle_busy: got %b expected 0", busy); end
      end
      if (oif.out_valid_o && ready) begin
        q_data.push_back(oif.out_data_o); q_tag.push_back(oif.out_tag_o);
        if (oif.out_last_o) nlast++;
      end
      if (nlast == 2) begin
        dump_req = 1'b0;
        step();
        break;
      end
      step();
    end
    step();
    n_chk += 4;
    if (nlast != 2) begin n_fail++; $display("FAIL held_dumps: got %0d expected 2", nlast); end
    if (idle_obs != 1) begin n_fail++; $display("FAIL held_gap: got %0d idle cycles expected 1", idle_obs); end
    if (q_data.size() != 2 * NREC) begin n_fail++; $display("FAIL held_count: got %0d expected %0d", q_data.size(), 2 * NREC); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL held_no_third: busy got %b expected 0", busy); end
    for (int k = 0; k < 2 * NREC; k++) begin
      n_chk += 2;
      if (q_data[k] !== exp_data(k % NREC, 32'd10, 32'd3, 32'd2, 32'h40)) begin n_fail++; $display("FAIL held_data%0d: got %h expected %h", k, q_data[k], exp_data(k % NREC, 32'd10, 32'd3, 32'd2, 32'h40)); end
      if (q_tag[k] !== exp_tag(k % NREC)) begin n_fail++; $display("FAIL held_tag%0d: got %h expected %h", k, q_tag[k], exp_tag(k % NREC)); end
    end
  endtask

  task automatic test_reset_mid_dump();
    bit tmo, found = 1'b0;
    ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (oif.out_valid_o && oif.out_tag_o == {TAG_MEM, 6'd2}) begin
        found = 1'b1;
        rst_n = 1'b0;
        #1;
        break;
      end
      step();
    end
    n_chk += 6;
    if (!found) begin n_fail++; $display("FAIL abort_reach: MEM idx2 never observed"); end
    if (oif.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", oif.out_valid_o); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (oif.out_tag_o !== 8'd0) begin n_fail++; $display("FAIL abort_tag: got %h expected 0", oif.out_tag_o); end
    if (oif.out_data_o !== 32'd0) begin n_fail++; $display("FAIL abort_data: got %h expected 0", oif.out_data_o); end
    if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL abort_mem_addr: got %h expected 0", mem_addr); end
    step();
    rst_n = 1'b1;
    pc = 32'h0000_0080;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; stall = (i == 0); flush = 1'b1;
      step();
    end
    start = 1'b0; stall = 1'b0; flush = 1'b0;
    drain(1'b1, tmo);
    n_chk += 2;
    if (tmo) begin n_fail++; $display("FAIL abort_timeout: no last record within bound"); end
    if (q_data.size() != NREC) begin n_fail++; $display("FAIL abort_count: got %0d expected %0d", q_data.size(), NREC); end
    for (int k = 0; k < NREC; k++) begin
      n_chk += 2;
      if (q_data[k] !== exp_data(k, 32'd4, 32'd1, 32'd4, 32'h80)) begin n_fail++; $display("FAIL abort_data%0d: got %h expected %h", k, q_data[k], exp_data(k, 32'd4, 32'd1, 32'd4, 32'h80)); end
      if (q_tag[k] !== exp_tag(k)) begin n_fail++; $display("FAIL abort_tag%0d: got %h expected %h", k, q_tag[k], exp_tag(k)); end
    end
  endtask

  task automatic test_saturation();
    bit tmo;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = 1'b1; stall = 1'b1;
      step();
    end
    start = 1'b0; stall = 1'b0;
    drain(1'b1, tmo);
    n_chk += 6;
    if (tmo) begin n_fail++; $display("FAIL sat_timeout: no last record within bound"); end
    if (q_data[0] !== 32'd20) begin n_fail++; $display("FAIL sat_wide_cycle: got %h expected %h", q_data[0], 32'd20); end
    if (q_data[1] !== 32'd20) begin n_fail++; $display("FAIL sat_wide_stall: got %h expected %h", q_data[1], 32'd20); end
    if (sq_data[0] !== 32'd15) begin n_fail++; $display("FAIL sat_cycle: got %h expected %h", sq_data[0], 32'd15); end
    if (sq_data[1] !== 32'd15) begin n_fail++; $display("FAIL sat_stall: got %h expected %h", sq_data[1], 32'd15); end
    if (sq_data[2] !== 32'd0) begin n_fail++; $display("FAIL sat_flush: got %h expected %h", sq_data[2], 32'd0); end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0]  = 32'hCAFE_0000;
    regs[1]  = 32'd5;
    regs[31] = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) mem[i] = 8'h10 + 8'(i);
    mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

    test_reset();
    test_counts();
    test_back_to_back();
    test_ready_stall();
    test_req_held();
    test_reset_mid_dump();
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
